// File: rtl/sr_pkg.sv
// Shared encodings for the SR flop command driver: command opcodes, FSM states,
// and the command-to-target-level mapping.
package sr_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Level the flop must settle to; hold/toggle are relative to q at accept time.
  function automatic logic op_target(input logic [1:0] op, input logic q);
    case (op)
      OP_CLEAR:  return 1'b0;
      OP_SET:    return 1'b1;
      OP_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

endpackage

// File: rtl/sr_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sr_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset)                  cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/sr_ff_driver.sv
// Command driver for an SR flop: encodes hold/clear/set/toggle onto exclusive s/r
// strobes and waits on q_fb for the target level. Define SR_STRETCH_EN for level drive.
module sr_ff_driver
  import sr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cmd_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SR_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  state_t            state, state_nxt;
  logic              target, target_nxt;
  logic [WAIT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic              s_nxt, r_nxt, done_nxt, err_nxt;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign wcnt_inc  = wcnt + WAIT_W'(1);

  // s/r are only ever produced from one target bit, so they cannot both be high.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    wcnt_nxt   = wcnt;
    s_nxt      = 1'b0;
    r_nxt      = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_nxt = op_target(cmd_op, q_fb);
          s_nxt      = (cmd_op != OP_HOLD) &&  target_nxt;
          r_nxt      = (cmd_op != OP_HOLD) && !target_nxt;
          state_nxt  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        s_nxt     = STRETCH & s;
        r_nxt     = STRETCH & r;
        wcnt_nxt  = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (q_fb == target) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wcnt_nxt = wcnt_inc;
          if (wcnt_inc == WAIT_W'(TIMEOUT_CYCLES)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            s_nxt = STRETCH & s;
            r_nxt = STRETCH & r;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      target <= 1'b0;
      wcnt   <= '0;
      s      <= 1'b0;
      r      <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      wcnt   <= wcnt_nxt;
      s      <= s_nxt;
      r      <= r_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  sr_sat_counter #(.CNT_W(CNT_W)) u_cmd_cnt (
    .clk(clk), .reset(reset), .inc(done_nxt), .cnt(cmd_cnt)
  );

  sr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .reset(reset), .inc(err_nxt), .cnt(err_cnt)
  );

endmodule

// File: doc/sr_ff_driver.md
Name: sr_ff_driver

Overview:
Transmit-side command driver for an SR flip-flop. It accepts level commands (hold/clear/set/toggle) over a valid/ready handshake and encodes each one onto legal s/r strobes. It then watches the flop's q feedback until the requested level appears, or flags a timeout. It sits between test/control logic and any sr_ff instance, and structurally guarantees s and r are never high together.

Parameters:
TIMEOUT_CYCLES, 4, max WAIT-state cycles allowed for q_fb to reach target before error (>=1)
CNT_W, 8, width of saturating command and error counters

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-low; reset=0 sampled at clk edge clears all state
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE; transfer when cmd_valid & cmd_ready at an edge
cmd_op  input  2  00 hold, 01 clear, 10 set, 11 toggle
q_fb  input  1  q output of driven flop
s  output  1  set strobe (registered)
r  output  1  reset strobe (registered)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: target reached
err  output  1  one-cycle pulse: timeout
cmd_cnt  output  CNT_W  completed commands (done pulses), saturating at all-ones
err_cnt  output  CNT_W  timeouts, saturating at all-ones

Behaviour:
- Reset (reset=0 at edge): state=IDLE; s=r=0; done=err=0; cmd_cnt=err_cnt=0; wait counter=0; cmd_ready=1 after reset edge. Reset mid-operation aborts the command with no done/err pulse.
- FSM states: IDLE, DRIVE, WAIT.
- IDLE: cmd_ready=1. On accept edge, latch target:
  - hold: target = q_fb
  - clear: target = 0
  - set: target = 1
  - toggle: target = ~q_fb (sampled at accept edge)
  - Next state DRIVE.
- DRIVE (exactly 1 cycle):
  - s = (target==1 and op!=hold)
  - r = (target==0 and op!=hold)
  - hold drives s=r=0.
  - Next state WAIT, wait counter=0.
- WAIT:
  - s=r=0 (pulse mode).
  - At each edge, if q_fb==target: done=1 for the following cycle, cmd_cnt+1, go to IDLE.
  - Else wait counter+1. If the counter reaches TIMEOUT_CYCLES without a match: err=1 for the following cycle, err_cnt+1, go to IDLE.
- Nominal latency with an ideal 1-cycle flop:
  - accept at edge E0, s/r high during E0–E1
  - flop updates at E1
  - match at E2, done high E2–E3, cmd_ready high from E2
  - next accept possible at E3
- done and err are never high together. Neither is ever high in IDLE except the cycle immediately after leaving WAIT.
- Invariant: s & r == 0 in every cycle, in every mode.
- Counters saturate: at all-ones, further increments hold the value.
- cmd_op is sampled only at the accept edge; changes while busy are ignored.

Optional Feature:
SR_STRETCH_EN
- Defined: level-drive mode. s or r stays asserted through WAIT until the match or timeout edge, then deasserts on the IDLE transition. Latency is unchanged.
- Undefined: single-cycle strobe in DRIVE only, as above.

Decomposition:
- Package sr_pkg:
  - cmd_op encodings OP_HOLD=2'b00, OP_CLEAR=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11
  - state encodings ST_IDLE, ST_DRIVE, ST_WAIT
- One sub-module, sr_sat_counter (parameter CNT_W; inputs clk, reset, inc; output cnt), instantiated twice for cmd_cnt and err_cnt.

Test Plan:
- Reset then set: reset=0 for 2 edges, then reset=1 with q_fb=0 and cmd_op=10 valid.
  - s=1 for exactly 1 cycle, r=0; model flop drives q_fb=1.
  - done pulses at E2; cmd_cnt=1; err_cnt=0.
- Clear from q_fb=1 (op 01): r=1 one cycle, s=0 throughout, done at E2, cmd_cnt increments.
- Toggle twice back-to-back (op 11, cmd_valid held high), starting q_fb=0:
  - first command gives s pulse, then done; second gives r pulse, then done.
  - second accept no earlier than E3; cmd_cnt=2.
- Hold with q_fb=1: s=r=0 every cycle; done at E2 (immediate match); q_fb unchanged.
- Timeout: set with q_fb stuck 0, TIMEOUT_CYCLES=4.
  - err high exactly 1 cycle, 4 edges after entering WAIT; err_cnt=1; done never high.
  - Then drive reset=0 during the next command's WAIT: s=r=0, no pulse, counters=0.
- Saturation, with CNT_W=2: 5 successful sets give cmd_cnt=3; a checker asserts s&r==0 throughout.
  - Rerun with SR_STRETCH_EN defined: s stays high until the match edge.
